// File: rtl/mxv_result_tx.sv
// Reply framer: latches a result vector and streams SOF, LEN, CMD, payload, [CHK], EOF to a UART byte port.
// Optional checksum byte before EOF when MXV_TX_CHECKSUM_EN is defined.
module mxv_result_tx #(
    parameter int          N_MAX     = 8,
    parameter int          RES_BYTES = 2,
    parameter logic [7:0]  CMD_CODE  = 8'h04,
    parameter logic [7:0]  SOF_BYTE  = 8'hFE,
    parameter logic [7:0]  EOF_BYTE  = 8'hEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic [3:0]                     vec_n_i,
    input  logic [N_MAX*8*RES_BYTES-1:0]   results_i,
    output logic [7:0]                     tx_data_o,
    output logic                           tx_send_o,
    input  logic                           tx_done_i,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int RES_W = 8 * RES_BYTES;
    localparam int NB    = N_MAX * RES_BYTES;
    localparam int IDXW  = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_FINISH} state_t;
    typedef enum logic [2:0] {
        PH_SOF, PH_LEN, PH_CMD, PH_PAY,
`ifdef MXV_TX_CHECKSUM_EN
        PH_CHK,
`endif
        PH_EOF
    } phase_t;

`ifdef MXV_TX_CHECKSUM_EN
    localparam phase_t PH_TAIL = PH_CHK;
`else
    localparam phase_t PH_TAIL = PH_EOF;
`endif

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [3:0]        n_q, n_d;
    logic [7:0]        pay_q [NB];
    logic [7:0]        len_w;
    logic [IDXW-1:0]   last_idx;
    logic [7:0]        cur_byte;
    logic              capture;
`ifdef MXV_TX_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    assign capture  = (state_q == S_IDLE) && start_i;
    assign len_w    = 8'(n_q) * 8'(RES_BYTES);
    assign last_idx = IDXW'(len_w - 8'd1);

    // Shadow copy held per payload byte, already in wire order (result 0 first, MSB byte first).
    for (genvar gi = 0; gi < N_MAX; gi++) begin : g_res
        for (genvar gj = 0; gj < RES_BYTES; gj++) begin : g_byte
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pay_q[gi*RES_BYTES+gj] <= 8'h00;
                end else if (capture) begin
                    pay_q[gi*RES_BYTES+gj] <= results_i[gi*RES_W + (RES_BYTES-1-gj)*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= PH_SOF;
            idx_q   <= '0;
            n_q     <= '0;
`ifdef MXV_TX_CHECKSUM_EN
            chk_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
`ifdef MXV_TX_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    always_comb begin
        cur_byte = 8'h00;
        case (phase_q)
            PH_SOF:  cur_byte = SOF_BYTE;
            PH_LEN:  cur_byte = len_w;
            PH_CMD:  cur_byte = CMD_CODE;
            PH_PAY:  cur_byte = pay_q[idx_q];
`ifdef MXV_TX_CHECKSUM_EN
            PH_CHK:  cur_byte = chk_q;
`endif
            PH_EOF:  cur_byte = EOF_BYTE;
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        n_d     = n_q;
`ifdef MXV_TX_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    phase_d = PH_SOF;
                    idx_d   = '0;
                    n_d     = (vec_n_i > 4'(N_MAX)) ? 4'(N_MAX) : vec_n_i;
`ifdef MXV_TX_CHECKSUM_EN
                    chk_d   = 8'h00;
`endif
                end
            end
            S_LOAD: state_d = S_WAIT;
            S_WAIT: begin
                if (tx_done_i) begin
                    state_d = S_LOAD;
`ifdef MXV_TX_CHECKSUM_EN
                    if (phase_q == PH_LEN || phase_q == PH_CMD || phase_q == PH_PAY)
                        chk_d = chk_q ^ cur_byte;
`endif
                    case (phase_q)
                        PH_SOF: phase_d = PH_LEN;
                        PH_LEN: phase_d = PH_CMD;
                        PH_CMD: phase_d = (n_q != 4'd0) ? PH_PAY : PH_TAIL;
                        PH_PAY: begin
                            if (idx_q == last_idx) phase_d = PH_TAIL;
                            else                   idx_d   = idx_q + 1'b1;
                        end
                        PH_EOF: state_d = S_FINISH;
                        default: phase_d = PH_EOF;
                    endcase
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_data_o = 8'h00;
        tx_send_o = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            S_LOAD: begin
                tx_data_o = cur_byte;
                tx_send_o = 1'b1;
                busy_o    = 1'b1;
            end
            S_WAIT: begin
                tx_data_o = cur_byte;
                busy_o    = 1'b1;
            end
            S_FINISH: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mxv_result_tx.sv
// Randomized bench for mxv_result_tx: a frame-level reference model predicts the byte stream of each reply.
module tb_mxv_result_tx;
    localparam int N_MAX = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   vec_n = 4'd0;
    logic [127:0] results = '0;
    logic [7:0]   tx_data;
    logic         tx_send, busy, done;
    logic         uart_done = 1'b0;
    logic         spur_done = 1'b0;
    logic         tx_done;

    assign tx_done = uart_done | spur_done;

    mxv_result_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .vec_n_i   (vec_n),
        .results_i (results),
        .tx_data_o (tx_data),
        .tx_send_o (tx_send),
        .tx_done_i (tx_done),
        .busy_o    (busy),
        .done_o    (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int send_cnt = 0;
    int tdone_cnt = 0;
    int done_cnt = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Observer: records every byte handed to the UART and counts handshake pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_send === 1'b1) begin
                got.push_back(tx_data);
                send_cnt++;
            end
            if (tx_done === 1'b1) tdone_cnt++;
            if (done === 1'b1) done_cnt++;
        end
    end

    // UART model: reports completion 10 cycles after each send.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_send === 1'b1) begin
                repeat (10) @(posedge clk);
                #1 uart_done = 1'b1;
                @(posedge clk);
                #1 uart_done = 1'b0;
            end
        end
    end

    // Expected reply for a request of vn results taken from the current vector.
    task automatic build_expected(input logic [3:0] vn);
        int n;
        logic [7:0]  len;
        logic [7:0]  chk;
        logic [15:0] word;
        n   = (int'(vn) > N_MAX) ? N_MAX : int'(vn);
        len = 8'(n * 2);
        exp_q.delete();
        exp_q.push_back(8'hFE);
        exp_q.push_back(len);
        exp_q.push_back(8'h04);
        chk = len ^ 8'h04;
        for (int i = 0; i < n; i++) begin
            word = results[i*16 +: 16];
            exp_q.push_back(word[15:8]);
            exp_q.push_back(word[7:0]);
            chk = chk ^ word[15:8] ^ word[7:0];
        end
`ifdef MXV_TX_CHECKSUM_EN
        exp_q.push_back(chk);
`endif
        exp_q.push_back(8'hEF);
    endtask

    task automatic randomize_results();
        for (int k = 0; k < 4; k++) results[k*32 +: 32] = $urandom();
    endtask

    task automatic run_frame(input string name, input logic [3:0] vn,
                             input bit perturb, input bit start_at_done);
        int cyc;
        int busy_drop;
        int done_base;
        bit finished;
        build_expected(vn);
        got.delete();
        done_base = done_cnt;
        @(posedge clk);
        #1 start = 1'b1;
        vec_n = vn;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_eq({name, "_send_latency"}, 32'(tx_send), 32'd1);
        cyc = 0;
        busy_drop = 0;
        finished = 1'b0;
        while (!finished && cyc < 3000) begin
            start = 1'b0;
            if (busy !== 1'b1) busy_drop++;
            if (perturb && cyc == 60) begin
                start = 1'b1;
                randomize_results();
                vec_n = 4'($urandom_range(0, 15));
            end
            if (done === 1'b1) begin
                finished = 1'b1;
                if (start_at_done) start = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check_eq({name, "_done_seen"}, 32'(finished), 32'd1);
        check_eq({name, "_busy_held"}, 32'(busy_drop), 32'd0);
        @(negedge clk);
        start = 1'b0;
        check_eq({name, "_busy_after"}, 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        check_eq({name, "_byte_count"}, 32'(got.size()), 32'(exp_q.size()));
        check_eq({name, "_done_pulses"}, 32'(done_cnt - done_base), 32'd1);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) check_eq($sformatf("%s_byte%0d", name, i), 32'(got[i]), 32'(exp_q[i]));
            else                check_eq($sformatf("%s_byte%0d_missing", name, i), 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
        $display("frame %s: vec_n=%0d bytes=%0d expected=%0d", name, vn, got.size(), exp_q.size());
    endtask

    initial begin
        int base;
        int sends_before;
        bit reached;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_tx_send", 32'(tx_send), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Completions arriving while idle must not provoke any send.
        sends_before = send_cnt;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 spur_done = 1'b1;
            @(posedge clk);
            #1 spur_done = 1'b0;
        end
        repeat (20) @(negedge clk);
        check_eq("idle_spurious_done", 32'(send_cnt - sends_before), 32'd0);

        results = '0;
        results[15:0]  = 16'h0009;
        results[31:16] = 16'h0012;
        run_frame("two_results", 4'd2, 1'b0, 1'b0);

        run_frame("empty", 4'd0, 1'b0, 1'b0);

        for (int i = 0; i < N_MAX; i++) results[i*16 +: 16] = 16'hA5A5;
        run_frame("clamped", 4'd12, 1'b0, 1'b0);

        randomize_results();
        run_frame("restart_ignored", 4'd5, 1'b1, 1'b0);
        run_frame("after_change", 4'd5, 1'b0, 1'b0);

        randomize_results();
        run_frame("start_at_done", 4'd3, 1'b0, 1'b1);

        // Reset partway through a frame.
        randomize_results();
        got.delete();
        base = tdone_cnt;
        @(posedge clk);
        #1 start = 1'b1;
        vec_n = 4'd4;
        @(posedge clk);
        #1 start = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 500 && !reached; c++) begin
            @(negedge clk);
            #1;
            if (tdone_cnt >= base + 3) reached = 1'b1;
        end
        check_eq("rst_mid_reached", 32'(reached), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_async_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_async_data", 32'(tx_data), 32'd0);
        @(posedge clk);
        #1;
        check_eq("rst_mid_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_mid_tx_send", 32'(tx_send), 32'd0);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_done", 32'(done), 32'd0);
        check_eq("rst_mid_bytes_sent", 32'(got.size()), 32'd3);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        run_frame("after_reset", 4'd4, 1'b0, 1'b0);

        for (int f = 0; f < 6; f++) begin
            randomize_results();
            run_frame($sformatf("rand%0d", f), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
